dma_priority_arbiter: RTL

Request/priority stage of the 4-channel DMA controller. It sits between the external DREQ pins and the timing-and-control state machine. It qualifies requests against mask and polarity settings and resolves them by fixed or rotating priority. It also runs the HRQ/HLDA hold handshake with the CPU and drives DACK plus the granted channel number to timing-and-control for the duration of one service.

---
 rtl/dma_priority_arbiter_if.sv | 27 ++
 rtl/dma_priority_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/dma_priority_arbiter_if.sv
// Bus between the DMA request/priority stage and its environment
// (DREQ pins, mode bits, CPU hold handshake, timing-and-control).
interface dma_priority_arbiter_if;
  logic [3:0] dreq;
  logic [3:0] mask_reg;
  logic       priority_type;
  logic       dreq_sense_active_low;
  logic       dack_sense_active_high;
  logic       hlda;
  logic       service_done;
  logic       hrq;
  logic [3:0] dack;
  logic       grant_valid;
  logic [1:0] grant_channel;

  modport master (
    output dreq, mask_reg, priority_type, dreq_sense_active_low,
           dack_sense_active_high, hlda, service_done,
    input  hrq, dack, grant_valid, grant_channel
  );

  modport slave (
    input  dreq, mask_reg, priority_type, dreq_sense_active_low,
           dack_sense_active_high, hlda, service_done,
    output hrq, dack, grant_valid, grant_channel
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 4-channel DMA request qualification, fixed/rotating priority resolution
// and HRQ/HLDA hold handshake driving DACK for one service at a time.
module dma_priority_arbiter (
  input  logic                          i_clk,
  input  logic                          i_rst,
  dma_priority_arbiter_if.slave         io_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_HLDA,
    S_SERVICE
  } state_t;

  state_t     r_state;
  logic [1:0] r_last_served;
  logic [1:0] r_grant_channel;
  logic [3:0] r_dack_raw;
  logic       r_hrq;
  logic       r_grant_valid;

  logic [3:0] w_req;
  logic       w_any_req;
  logic [1:0] w_start;
  logic [1:0] w_idx;
  logic [1:0] w_winner;

  assign w_req     = (io_bus.dreq ^ {4{io_bus.dreq_sense_active_low}}) & ~io_bus.mask_reg;
  assign w_any_req = |w_req;

  // Search starts at channel 0 in fixed mode, else just past the last served
  // channel; scanning from the far end lets the nearest requester win.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_start  = io_bus.priority_type ? (r_last_served + 2'd1) : 2'd0;
    w_idx    = 2'd0;
    w_winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = w_start + 2'(k);
      if (w_req[w_idx]) w_winner = w_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_last_served   <= 2'd3;
      r_grant_channel <= 2'd0;
      r_dack_raw      <= 4'b0000;
      r_hrq           <= 1'b0;
      r_grant_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_channel <= w_winner;
            r_hrq           <= 1'b1;
            r_state         <= S_WAIT_HLDA;
          end
        end
        S_WAIT_HLDA: begin
          // A withdrawn request beats a simultaneous HLDA.
          if (!w_req[r_grant_channel]) begin
            r_hrq   <= 1'b0;
            r_state <= S_IDLE;
          end else if (io_bus.hlda) begin
            r_dack_raw    <= 4'b0001 << r_grant_channel;
            r_grant_valid <= 1'b1;
            r_state       <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (io_bus.service_done || !io_bus.hlda) begin
            r_hrq         <= 1'b0;
            r_dack_raw    <= 4'b0000;
            r_grant_valid <= 1'b0;
            r_state       <= S_IDLE;
            if (io_bus.service_done) r_last_served <= r_grant_channel;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.hrq           = r_hrq;
  assign io_bus.grant_valid   = r_grant_valid;
  assign io_bus.grant_channel = r_grant_channel;
  assign io_bus.dack          = io_bus.dack_sense_active_high ? r_dack_raw : ~r_dack_raw;

endmodule
